// File: rtl/mpram_lut_nr1w_pkg.sv
// Shared types and helpers for the N-read/1-write LUT RAM array.
// Optional feature macro: MPRAM_BYPASS_EN (write-first bypass on read ports).
package mpram_pkg;

    // Sweep/idle sequencing states
    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } mpram_state_e;

    // Address width that never collapses to zero bits, even for tiny depths
    function automatic int awid_f(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mpram_lut_nr1w_if.sv
// Bus bundle for mpram_lut_nr1w: write port, soft clear, flat read ports, busy flag.
// Optional feature macro: MPRAM_BYPASS_EN (affects only the RAM, not this bundle).
interface mpram_lut_nr1w_if #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 64,
    parameter int NR    = 3
);
    import mpram_pkg::*;

    localparam int AWID = awid_f(DEPTH);

    logic                  WEN;
    logic [AWID-1:0]       AW;
    logic [WIDTH-1:0]      DI;
    logic                  CLR;
    logic [NR*AWID-1:0]    A;
    logic [NR*WIDTH-1:0]   Q;
    logic                  BUSY;

    // Requester side: issues writes, clears and read addresses
    modport master (
        output WEN, AW, DI, CLR, A,
        input  Q, BUSY
    );

    // RAM side
    modport slave (
        input  WEN, AW, DI, CLR, A,
        output Q, BUSY
    );

endinterface

// File: rtl/mpram_lut_nr1w_lut_bank.sv
// One replicated bank: asynchronous read, synchronous write, no reset on
// the storage so it maps onto distributed (LUT) RAM. Contents are defined
// only by the clear sweep driven from the top level.
// Optional feature macro: MPRAM_BYPASS_EN (handled in the top level only).
module lut_bank_1r1w #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 64
) (
    input  logic                                CLK,
    input  logic                                we,
    input  logic [mpram_pkg::awid_f(DEPTH)-1:0] wa,
    input  logic [WIDTH-1:0]                    wd,
    input  logic [mpram_pkg::awid_f(DEPTH)-1:0] ra,
    output logic [WIDTH-1:0]                    rd
);
    import mpram_pkg::*;

    localparam int AWID = awid_f(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    // Single synchronous write port shared by sweep and user paths
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    // Zero-latency read
    assign rd = mem[ra];

endmodule

// File: rtl/mpram_lut_nr1w.sv
// Parametrised N-read/1-write distributed RAM with clear-on-reset and a
// soft-clear sweep. Each read port owns a replicated bank; all banks share
// one write port, muxed between the clear sweep (cnt, 0) and the user (AW, DI).
// BUSY is high for the whole sweep; during it every read lane is forced to
// zero and user writes/clears are dropped.
// Optional feature macro: MPRAM_BYPASS_EN -- a read port addressing AW while
// a user write is committing returns DI (write-first) instead of old data.
module mpram_lut_nr1w #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 64,
    parameter int NR    = 3
) (
    input  logic           CLK,
    input  logic           RST,
    mpram_lut_nr1w_if.slave bus
);
    import mpram_pkg::*;

    localparam int              AWID = awid_f(DEPTH);
    localparam logic [AWID-1:0] LAST = AWID'(DEPTH - 1);

    mpram_state_e                 state;
    logic [AWID-1:0]              cnt;
    logic                         busy_q;

    logic                         user_wr;
    logic                         wr_en;
    logic [AWID-1:0]              wr_addr;
    logic [WIDTH-1:0]             wr_data;

    logic [NR-1:0][WIDTH-1:0]     rd_lanes;
    logic [NR-1:0][WIDTH-1:0]     q_lanes;

    // Sweep sequencer: counter runs 0..DEPTH-1 and exits on the explicit
    // compare, so the counter never relies on wrap-around. BUSY is kept as
    // its own register so the output is glitch-free.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= S_CLEAR;
            cnt    <= '0;
            busy_q <= 1'b1;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (cnt == LAST) begin
                        state  <= S_IDLE;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (bus.CLR) begin
                        state  <= S_CLEAR;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= S_CLEAR;
                    cnt    <= '0;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end

    // A user write commits only when idle and not losing to a clear request
    assign user_wr = !busy_q && bus.WEN && !bus.CLR;

    // Shared write port: sweep owns it while busy, user otherwise
    always_comb begin
        wr_en   = user_wr;
        wr_addr = bus.AW;
        wr_data = bus.DI;
        if (busy_q) begin
            wr_en   = 1'b1;
            wr_addr = cnt;
            wr_data = '0;
        end
    end

    // One bank per read port so every port gets a private async read
    for (genvar g = 0; g < NR; g++) begin : g_bank
        lut_bank_1r1w #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_bank (
            .CLK (CLK),
            .we  (wr_en),
            .wa  (wr_addr),
            .wd  (wr_data),
            .ra  (bus.A[g*AWID +: AWID]),
            .rd  (rd_lanes[g])
        );
    end

    // Read lanes: masked to zero while busy (hides pre-sweep garbage),
    // optionally bypassed with the committing write data.
    always_comb begin
        q_lanes = '0;
        for (int i = 0; i < NR; i++) begin
            q_lanes[i] = busy_q ? '0 : rd_lanes[i];
`ifdef MPRAM_BYPASS_EN
            if (user_wr && (bus.A[i*AWID +: AWID] == bus.AW)) begin
                q_lanes[i] = bus.DI;
            end
`endif
        end
    end

    assign bus.Q    = q_lanes;
    assign bus.BUSY = busy_q;

endmodule

// File: tb/tb_mpram_lut_nr1w.sv
// Directed bench for mpram_lut_nr1w (WIDTH=8, DEPTH=64, NR=3).
// Optional feature macro: MPRAM_BYPASS_EN changes the same-cycle collision expectation.
module tb_mpram_lut_nr1w;

    localparam int WIDTH = 8;
    localparam int DEPTH = 64;
    localparam int NR    = 3;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mpram_lut_nr1w_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NR(NR)) bus ();

    mpram_lut_nr1w #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NR(NR)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the three read addresses and let Q settle
    task automatic set_addr(input int a0, input int a1, input int a2);
        bus.A = {6'(a2), 6'(a1), 6'(a0)};
        #1;
    endtask

    // Step cycles until BUSY drops (bounded); counts rising edges and nonzero Q samples
    task automatic wait_sweep(output int cyc, output int qbad);
        cyc  = 0;
        qbad = 0;
        while (bus.BUSY === 1'b1 && cyc < 200) begin
            if (bus.Q !== 24'h0) qbad++;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        int cyc, qbad;
        rst     = 1'b1;
        bus.WEN = 1'b0;
        bus.AW  = '0;
        bus.DI  = '0;
        bus.CLR = 1'b0;
        set_addr(0, 1, 2);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 1", bus.BUSY);
        end
        n_checks++;
        if (bus.Q !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_q: got %h expected 000000", bus.Q);
        end
        rst = 1'b0;
        wait_sweep(cyc, qbad);
        n_checks++;
        if (cyc !== 64) begin
            n_fail++;
            $display("FAIL reset_sweep_len: got %0d expected 64", cyc);
        end
        n_checks++;
        if (qbad !== 0) begin
            n_fail++;
            $display("FAIL reset_sweep_qmask: got %0d nonzero samples expected 0", qbad);
        end
        for (int e = 0; e < DEPTH; e++) begin
            @(negedge clk);
            set_addr(e, (e + 21) % DEPTH, (e + 42) % DEPTH);
            n_checks++;
            if (bus.Q !== 24'h0) begin
                n_fail++;
                $display("FAIL reset_entry_%0d: got %h expected 000000", e, bus.Q);
            end
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        bus.WEN = 1'b1;
        bus.AW  = 6'd5;
        bus.DI  = 8'hA5;
        @(negedge clk);
        bus.WEN = 1'b0;
        set_addr(5, 5, 5);
        n_checks++;
        if (bus.Q !== 24'hA5A5A5) begin
            n_fail++;
            $display("FAIL write_read_all5: got %h expected a5a5a5", bus.Q);
        end
        set_addr(5, 6, 5);
        n_checks++;
        if (bus.Q !== 24'hA500A5) begin
            n_fail++;
            $display("FAIL write_read_a1_6: got %h expected a500a5", bus.Q);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.WEN = 1'b1;
        bus.AW  = 6'd10;
        bus.DI  = 8'h11;
        @(negedge clk);
        bus.AW  = 6'd11;
        bus.DI  = 8'h22;
        @(negedge clk);
        bus.AW  = 6'd12;
        bus.DI  = 8'h33;
        @(negedge clk);
        bus.WEN = 1'b0;
        set_addr(10, 11, 12);
        n_checks++;
        if (bus.Q !== 24'h332211) begin
            n_fail++;
            $display("FAIL back_to_back: got %h expected 332211", bus.Q);
        end
        n_checks++;
        if (bus.BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_busy: got %b expected 0", bus.BUSY);
        end
    endtask

    task automatic test_collision();
        logic [7:0] exp_same;
`ifdef MPRAM_BYPASS_EN
        exp_same = 8'h3C;
`else
        exp_same = 8'h00;
`endif
        @(negedge clk);
        bus.WEN = 1'b1;
        bus.AW  = 6'd9;
        bus.DI  = 8'h3C;
        set_addr(9, 0, 0);
        n_checks++;
        if (bus.Q[7:0] !== exp_same) begin
            n_fail++;
            $display("FAIL collision_same_cycle: got %h expected %h", bus.Q[7:0], exp_same);
        end
        @(negedge clk);
        bus.WEN = 1'b0;
        #1;
        n_checks++;
        if (bus.Q[7:0] !== 8'h3C) begin
            n_fail++;
            $display("FAIL collision_next_cycle: got %h expected 3c", bus.Q[7:0]);
        end
    endtask

    task automatic test_soft_clear();
        int cyc, qbad;
        for (int e = 0; e < DEPTH; e++) begin
            @(negedge clk);
            bus.WEN = 1'b1;
            bus.AW  = 6'(e);
            bus.DI  = 8'(e);
        end
        @(negedge clk);
        bus.WEN = 1'b0;
        set_addr(1, 63, 40);
        n_checks++;
        if (bus.Q !== 24'h283F01) begin
            n_fail++;
            $display("FAIL fill_readback: got %h expected 283f01", bus.Q);
        end
        // Clear and write in the same cycle: clear wins
        bus.CLR = 1'b1;
        bus.WEN = 1'b1;
        bus.AW  = 6'd1;
        bus.DI  = 8'hFF;
        @(negedge clk);
        bus.CLR = 1'b0;
        bus.WEN = 1'b0;
        wait_sweep(cyc, qbad);
        n_checks++;
        if (cyc !== 64) begin
            n_fail++;
            $display("FAIL clear_sweep_len: got %0d expected 64", cyc);
        end
        n_checks++;
        if (qbad !== 0) begin
            n_fail++;
            $display("FAIL clear_sweep_qmask: got %0d nonzero samples expected 0", qbad);
        end
        @(negedge clk);
        set_addr(1, 63, 40);
        n_checks++;
        if (bus.Q !== 24'h0) begin
            n_fail++;
            $display("FAIL clear_entries: got %h expected 000000", bus.Q);
        end
    endtask

    task automatic test_write_during_busy();
        int cyc, qbad;
        @(negedge clk);
        bus.WEN = 1'b1;
        bus.AW  = 6'd2;
        bus.DI  = 8'h77;
        @(negedge clk);
        bus.WEN = 1'b0;
        bus.CLR = 1'b1;
        @(negedge clk);
        bus.CLR = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_at_cycle10: got %b expected 1", bus.BUSY);
        end
        bus.WEN = 1'b1;
        bus.AW  = 6'd2;
        bus.DI  = 8'h11;
        @(negedge clk);
        bus.WEN = 1'b0;
        wait_sweep(cyc, qbad);
        n_checks++;
        if (cyc !== 53) begin
            n_fail++;
            $display("FAIL busy_write_remaining: got %0d expected 53", cyc);
        end
        @(negedge clk);
        set_addr(2, 2, 2);
        n_checks++;
        if (bus.Q !== 24'h0) begin
            n_fail++;
            $display("FAIL busy_write_dropped: got %h expected 000000", bus.Q);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int cyc, qbad;
        @(negedge clk);
        bus.WEN = 1'b1;
        bus.AW  = 6'd40;
        bus.DI  = 8'hC3;
        @(negedge clk);
        bus.AW  = 6'd50;
        bus.DI  = 8'h7E;
        @(negedge clk);
        bus.WEN = 1'b0;
        bus.CLR = 1'b1;
        @(negedge clk);
        bus.CLR = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        set_addr(40, 50, 0);
        n_checks++;
        if (bus.BUSY !== 1'b1 || bus.Q !== 24'h0) begin
            n_fail++;
            $display("FAIL rst_mid_sweep_assert: got busy=%b q=%h expected busy=1 q=000000", bus.BUSY, bus.Q);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_sweep_hold: got %b expected 1", bus.BUSY);
        end
        rst = 1'b0;
        wait_sweep(cyc, qbad);
        n_checks++;
        if (cyc !== 64) begin
            n_fail++;
            $display("FAIL rst_mid_sweep_len: got %0d expected 64", cyc);
        end
        for (int e = 0; e < DEPTH; e++) begin
            @(negedge clk);
            set_addr(e, (DEPTH - 1) - e, (e + 32) % DEPTH);
            n_checks++;
            if (bus.Q !== 24'h0) begin
                n_fail++;
                $display("FAIL rst_mid_sweep_entry_%0d: got %h expected 000000", e, bus.Q);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_collision();
        test_soft_clear();
        test_write_during_busy();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
